// File: rtl/umul_sched_if.sv
// Fixed-point parameter carrier plus the common clock/reset shared by the
// scheduler and the multiplier it feeds.
interface fixedp #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SCALE = 8
);
   logic clk;
   logic reset;

   modport master (output clk, output reset);
   modport slave  (input clk, input reset);
endinterface

// File: rtl/umul_sched.sv
// Round-robin scheduler sharing one free-running pipelined umul among N_REQ
// requesters; a tag pipeline tracks each product's owner through the multiplier.
module umul_sched #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned WIDTH       = 16
) (
   fixedp.slave                      g,
   input  logic                      en,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*WIDTH-1:0]    req_a,
   input  logic [N_REQ*WIDTH-1:0]    req_b,
   output logic [WIDTH-1:0]          mul_a,
   output logic [WIDTH-1:0]          mul_b,
   input  logic [WIDTH-1:0]          mul_f,
   output logic [WIDTH-1:0]          res_f,
   output logic [N_REQ-1:0]          res_valid,
   output logic [$clog2(N_REQ)-1:0]  res_id,
   output logic                      busy
);
   localparam int unsigned IW = $clog2(N_REQ);

   logic [IW-1:0]      ptr;
   logic [IW-1:0]      ptr_nxt;
   logic [IW-1:0]      grant_id;
   logic               accept;
   logic [MUL_LATENCY:0] tag_vld;
   logic [IW-1:0]      tag_id [MUL_LATENCY+1];

   // First valid requester at or above the pointer, wrapping; no grants in reset.
   always_comb begin
      int unsigned idx;
      req_ready = '0;
      grant_id  = '0;
      accept    = 1'b0;
      idx       = 0;
      if (en && !g.reset) begin
         for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            if (!accept && req_valid[idx]) begin
               accept   = 1'b1;
               grant_id = IW'(idx);
            end
         end
      end
      if (accept) req_ready[grant_id] = 1'b1;
   end

   assign ptr_nxt = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;

   always_ff @(posedge g.clk) begin
      if (g.reset) begin
         ptr       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         tag_vld   <= '0;
         res_f     <= '0;
         res_valid <= '0;
         res_id    <= '0;
         for (int unsigned s = 0; s <= MUL_LATENCY; s++) tag_id[s] <= '0;
      end else begin
         if (accept) begin
            ptr   <= ptr_nxt;
            mul_a <= req_a[grant_id*WIDTH +: WIDTH];
            mul_b <= req_b[grant_id*WIDTH +: WIDTH];
         end
         // Tag pipeline never stalls: a bubble enters whenever nothing is accepted.
         tag_vld[0] <= accept;
         tag_id[0]  <= grant_id;
         for (int unsigned s = 1; s <= MUL_LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
         if (tag_vld[MUL_LATENCY]) begin
            res_f     <= mul_f;
            res_id    <= tag_id[MUL_LATENCY];
            res_valid <= N_REQ'(1) << tag_id[MUL_LATENCY];
         end else begin
            res_valid <= '0;
         end
      end
   end

   assign busy = (|tag_vld) | (|res_valid);
endmodule

// File: tb/tb_umul_sched.sv
// Scoreboard bench for umul_sched: a requester/arbitration model pushes expected
// products; a monitor pops them when results appear.
module tb_umul_sched;
   localparam int unsigned N = 4;
   localparam int unsigned L = 3;
   localparam int unsigned W = 16;
   localparam int unsigned S = 8;

   typedef struct {
      int unsigned id;
      logic [W-1:0] f;
      int          due;
   } item_t;

   fixedp #(.WIDTH(W), .SCALE(S)) g ();

   logic              en;
   logic [N-1:0]      req_valid, req_ready, res_valid;
   logic [N*W-1:0]    req_a, req_b;
   logic [W-1:0]      mul_a, mul_b, mul_f, res_f;
   logic [1:0]        res_id;
   logic              busy;

   umul_sched #(.N_REQ(N), .MUL_LATENCY(L), .WIDTH(W)) dut (
      .g(g.slave), .en(en), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_f(mul_f),
      .res_f(res_f), .res_valid(res_valid), .res_id(res_id), .busy(busy)
   );

   // Stand-in umul: (a*b) >> SCALE truncated to WIDTH, L-cycle pipeline.
   logic [W-1:0] fp [L];
   always @(posedge g.clk) begin
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      fp[0] <= p[S +: W];
      for (int s = 1; s < L; s++) fp[s] <= fp[s-1];
   end
   assign mul_f = fp[L-1];

   initial g.clk = 1'b0;
   always #5 g.clk = ~g.clk;

   int cycle = 0;
   always @(posedge g.clk) cycle++;

   int tests = 0;
   int fails = 0;
   bit mon_on = 0;
   bit chk_busy = 1;
   item_t sb[$];

   bit           pend [N];
   logic [W-1:0] a_r  [N];
   logic [W-1:0] b_r  [N];
   int unsigned  mptr = 0;

   function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[S +: W];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = pend[i];
         req_a[i*W +: W]    = a_r[i];
         req_b[i*W +: W]    = b_r[i];
      end
   endtask

   // Round-robin reference: first pending requester from mptr, wrapping.
   task automatic check_grant();
      logic [N-1:0] exp_g;
      int unsigned gid;
      exp_g = '0;
      gid = 0;
      if (en && !g.reset) begin
         for (int unsigned off = 0; off < N; off++) begin
            int unsigned id;
            id = (mptr + off) % N;
            if (pend[id] && exp_g == '0) begin
               exp_g[id] = 1'b1;
               gid = id;
            end
         end
      end
      check("req_ready", 32'(req_ready), 32'(exp_g));
      if (exp_g != '0) begin
         sb.push_back('{gid, prod(a_r[gid], b_r[gid]), cycle + L + 2});
         mptr = (gid + 1) % N;
         pend[gid] = 1'b0;
      end
   endtask

   task automatic tick();
      drive();
      @(negedge g.clk);
      check_grant();
      @(posedge g.clk);
      #1;
   endtask

   task automatic clear_pend();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
   endtask

   always @(posedge g.clk) begin
      item_t it;
      #1;
      if (mon_on) begin
         if (chk_busy) check("busy", 32'(busy), 32'(sb.size() != 0));
         if (sb.size() != 0 && sb[0].due == cycle) begin
            it = sb.pop_front();
            check("res_valid", 32'(res_valid), 32'(1) << it.id);
            check("res_id", 32'(res_id), it.id);
            check("res_f", 32'(res_f), 32'(it.f));
         end else begin
            check("res_valid_idle", 32'(res_valid), 32'd0);
         end
      end
   end

   initial begin
      en = 1'b0;
      g.reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         a_r[i] = '0;
         b_r[i] = '0;
      end
      drive();
      repeat (3) @(posedge g.clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);
      check("rst_res_f", 32'(res_f), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      g.reset = 1'b0;
      en = 1'b1;
      mon_on = 1'b1;

      // Single request
      pend[0] = 1'b1; a_r[0] = 16'h0180; b_r[0] = 16'h0200;
      tick();
      repeat (7) tick();

      // Full contention, requests re-raised every cycle
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1; a_r[i] = 16'h0100; b_r[i] = 16'((i + 1) << 8);
      end
      repeat (12) begin
         tick();
         for (int i = 0; i < N; i++) pend[i] = 1'b1;
      end
      clear_pend();
      repeat (6) tick();

      // Fairness after wrap: move pointer to 3, then 3, 0, 2 valid
      pend[2] = 1'b1; a_r[2] = 16'h0300; b_r[2] = 16'h0080;
      tick();
      pend[3] = 1'b1; a_r[3] = 16'h0140; b_r[3] = 16'h0400;
      pend[0] = 1'b1; a_r[0] = 16'h0220; b_r[0] = 16'h0110;
      pend[2] = 1'b1; a_r[2] = 16'h0500; b_r[2] = 16'h0030;
      repeat (4) tick();
      repeat (5) tick();

      // en gating with products in flight
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1; a_r[i] = 16'(16'h0111 * (i + 1)); b_r[i] = 16'h0233;
      end
      repeat (2) tick();
      en = 1'b0;
      repeat (7) tick();
      en = 1'b1;
      repeat (3) tick();
      clear_pend();
      repeat (6) tick();

      // Reset mid-flight after three accepts
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1; a_r[i] = 16'h0400; b_r[i] = 16'(16'h0100 + i);
      end
      repeat (3) tick();
      g.reset = 1'b1;
      sb.delete();
      chk_busy = 1'b0;
      mptr = 0;
      tick();
      g.reset = 1'b0;
      check("mid_rst_mul_a", 32'(mul_a), 32'd0);
      check("mid_rst_res_f", 32'(res_f), 32'd0);
      check("mid_rst_res_id", 32'(res_id), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      chk_busy = 1'b1;
      repeat (3) tick();
      clear_pend();
      repeat (6) tick();

      // Handshake hold: req 1 re-raised every cycle, req 2 waits its turn
      pend[2] = 1'b1; a_r[2] = 16'h0321; b_r[2] = 16'h0456;
      for (int k = 0; k < 6; k++) begin
         pend[1] = 1'b1; a_r[1] = 16'(16'h0100 + k); b_r[1] = 16'h0200;
         tick();
      end
      clear_pend();
      repeat (6) tick();

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         en = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               a_r[i] = 16'($urandom);
               b_r[i] = 16'($urandom);
            end
         end
         tick();
      end
      en = 1'b1;
      clear_pend();
      repeat (10) tick();
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
